universal_shift_reg_core: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REG_CORE -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 4, register width in bits (minimum 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-high (asserted = 1).
REQ-004 Port: select  input  2  mode select: 0 hold, 1 shift right, 2 shift left, 3 parallel load.
REQ-005 Port: p_din  input  WIDTH  parallel load data.
REQ-006 Port: s_left_din  input  1  serial input entering at bit 0 during shift left.
REQ-007 Port: s_right_din  input  1  serial input entering at bit WIDTH-1 during shift right.
REQ-008 Port: p_dout  output  WIDTH  parallel output, driven directly by the internal register.
REQ-009 Port: s_left_dout  output  1  serial output, equal to p_dout[0].
REQ-010 Port: s_right_dout  output  1  serial output, equal to p_dout[WIDTH-1].

Function
REQ-011 The block SHALL hold a single WIDTH-bit register R; p_dout SHALL equal R at all times.
REQ-012 select=0 (hold): R SHALL keep its value.
REQ-013 select=1 (shift right): R SHALL become {s_right_din, R[WIDTH-1:1]}; R[0] is discarded.
REQ-014 select=2 (shift left): R SHALL become {R[WIDTH-2:0], s_left_din}; R[WIDTH-1] is discarded.
REQ-015 select=3 (parallel load): R SHALL become p_din.
REQ-016 Each operation SHALL take effect at the rising edge where select is sampled: one-cycle latency, no pipelining, no handshake.
REQ-017 s_left_dout and s_right_dout SHALL be combinational taps of R with no additional register stage.
REQ-018 Serial inputs SHALL be ignored in hold and load modes; p_din SHALL be ignored in hold and shift modes.
REQ-019 A select change SHALL take effect on the next rising edge with no dead cycle.
REQ-020 Inputs that are X/unknown while reset is asserted SHALL NOT affect R.

Reset
REQ-021 With rst_n=1 at a rising edge, R SHALL become all zeros, overriding every select mode.
REQ-022 After reset: p_dout=0, s_left_dout=0, s_right_dout=0.
REQ-023 Asserting reset mid-operation SHALL clear R at the next rising edge. The operation in progress SHALL be lost.
REQ-024 Reset SHALL have no asynchronous effect; between edges, R keeps its value.

Verification
REQ-025 Reset: rst_n=1 for one edge, select=3, p_din=1101 -> p_dout=0000, both serial outputs 0.
REQ-026 Load then shift right: load 1101, then select=1 with s_right_din=0 for 4 edges -> p_dout 0110, 0011, 0001, 0000. s_left_dout follows 0,1,1,0.
REQ-027 Load then shift left: load 1101, then select=2 with s_left_din=1 for 3 edges -> p_dout 1011, 0111, 1111. s_right_dout follows 1,0,1.
REQ-028 Hold: load 1010, then select=0 for 5 edges while p_din and serial inputs toggle -> p_dout stays 1010.
REQ-029 Shift right with s_right_din=1 from 0000 for 4 edges -> 1000, 1100, 1110, 1111.
REQ-030 Reset mid-shift: during a shift-left sequence at p_dout=0111, assert rst_n=1 for one edge -> p_dout=0000. After release, select=3 with p_din=0101 -> p_dout=0101.

Source files
------------

// File: rtl/universal_shift_reg_core.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Serial taps come straight off the register with no extra stage.
module universal_shift_reg_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout
);

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] SHR  = 2'd1;
  localparam logic [1:0] SHL  = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;

  always_comb begin
    r_next = r;
    unique case (1'b1)
      (select == SHR):  r_next = {s_right_din, r[WIDTH-1:1]};
      (select == SHL):  r_next = {r[WIDTH-2:0], s_left_din};
      (select == LOAD): r_next = p_din;
      (select == HOLD): r_next = r;
      default:          r_next = r;
    endcase
  end

  // rst_n is active-high here; it wins over every select mode
  always_ff @(posedge clk) begin
    if (rst_n) r <= '0;
    else       r <= r_next;
  end

  assign p_dout       = r;
  assign s_left_dout  = r[0];
  assign s_right_dout = r[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg_core.sv
// Bench for universal_shift_reg_core: directed scenarios plus random
// traffic compared against an arithmetic reference model.
module tb_universal_shift_reg_core;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic [1:0]   select;
  logic [W-1:0] p_din;
  logic         s_left_din;
  logic         s_right_din;
  logic [W-1:0] p_dout;
  logic         s_left_dout;
  logic         s_right_dout;

  int tests;
  int fails;
  int m;

  universal_shift_reg_core #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .select       (select),
    .p_din        (p_din),
    .s_left_din   (s_left_din),
    .s_right_din  (s_right_din),
    .p_dout       (p_dout),
    .s_left_dout  (s_left_dout),
    .s_right_dout (s_right_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input bit rst, input int sel, input int p,
                       input bit sl, input bit sr);
    @(negedge clk);
    rst_n       = rst;
    select      = sel[1:0];
    p_din       = p[W-1:0];
    s_left_din  = sl;
    s_right_din = sr;
    @(posedge clk);
    #1;
    if (rst) m = 0;
    else begin
      case (sel)
        1: m = (m >> 1) | (int'(sr) << (W - 1));
        2: m = ((m << 1) | int'(sl)) & MASK;
        3: m = p & MASK;
        default: m = m;
      endcase
    end
    check("model_pout", int'(p_dout), m);
    check("model_sl", int'(s_left_dout), m & 1);
    check("model_sr", int'(s_right_dout), (m >> (W - 1)) & 1);
  endtask

  initial begin
    int exp_q[$];
    int bit_q[$];
    tests = 0;
    fails = 0;
    m = 0;
    rst_n = 1'b1;
    select = 2'd0;
    p_din = '0;
    s_left_din = 1'b0;
    s_right_din = 1'b0;

    apply(1, 3, 'b1101, 0, 0);
    check("reset_pout", int'(p_dout), 0);
    check("reset_sl", int'(s_left_dout), 0);
    check("reset_sr", int'(s_right_dout), 0);

    apply(0, 3, 'b1101, 0, 0);
    check("load_1101", int'(p_dout), 'b1101);
    exp_q = '{'b0110, 'b0011, 'b0001, 'b0000};
    bit_q = '{0, 1, 1, 0};
    foreach (exp_q[i]) begin
      apply(0, 1, 'b1010, 1, 0);
      check("shr_pout", int'(p_dout), exp_q[i]);
      check("shr_sl", int'(s_left_dout), bit_q[i]);
    end

    apply(0, 3, 'b1101, 0, 0);
    exp_q = '{'b1011, 'b0111, 'b1111};
    bit_q = '{1, 0, 1};
    foreach (exp_q[i]) begin
      apply(0, 2, 'b0000, 1, 0);
      check("shl_pout", int'(p_dout), exp_q[i]);
      check("shl_sr", int'(s_right_dout), bit_q[i]);
    end

    apply(0, 3, 'b1010, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, i * 3 + 1, i[0], ~i[0]);
      check("hold", int'(p_dout), 'b1010);
    end

    apply(1, 0, 0, 0, 0);
    exp_q = '{'b1000, 'b1100, 'b1110, 'b1111};
    foreach (exp_q[i]) begin
      apply(0, 1, 0, 0, 1);
      check("shr_fill", int'(p_dout), exp_q[i]);
    end

    apply(0, 3, 'b1101, 0, 0);
    apply(0, 2, 0, 1, 0);
    apply(0, 2, 0, 1, 0);
    check("pre_rst", int'(p_dout), 'b0111);
    @(negedge clk);
    rst_n = 1'b1;
    select = 2'd2;
    #2;
    check("rst_sync", int'(p_dout), 'b0111);
    @(posedge clk);
    #1;
    m = 0;
    check("rst_mid", int'(p_dout), 0);
    apply(0, 3, 'b0101, 0, 0);
    check("post_rst_load", int'(p_dout), 'b0101);

    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, MASK)), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
